// File: rtl/prio_encoder_pipe.sv
// Two-stage pipelined priority encoder: stage 1 encodes fixed-size groups,
// stage 2 picks the winning group, honouring a per-vector LSB/MSB-first mode.
module prio_encoder_pipe #(
   parameter int WIDTH = 18,
   parameter int IDX_W = 5,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_vec,
   input  logic             in_msb_first,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_index,
   output logic             out_zero
);

   localparam int NG = (WIDTH + GROUP - 1) / GROUP;
   localparam int LW = (GROUP > 1) ? $clog2(GROUP) : 1;
   localparam int GW = (NG > 1) ? $clog2(NG) : 1;
   localparam int PW = NG * GROUP;

   generate
      if (WIDTH < 2 || WIDTH > 64) begin : g_width_chk
         $error("prio_encoder_pipe: WIDTH must be in 2..64");
      end
      if ((64'd1 << IDX_W) < 64'(WIDTH)) begin : g_idx_chk
         $error("prio_encoder_pipe: IDX_W too narrow for WIDTH");
      end
   endgenerate

   logic                   s1_valid_q, s1_valid_d;
   logic                   s1_msb_q, s1_msb_d;
   logic [NG-1:0]          s1_any_q, s1_any_d;
   logic [NG-1:0][LW-1:0]  s1_lidx_q, s1_lidx_d;
   logic                   out_valid_q, out_valid_d;
   logic [IDX_W-1:0]       out_index_q, out_index_d;
   logic                   out_zero_q, out_zero_d;

   logic                   s1_load;
   logic                   s2_load;
   logic [PW-1:0]          pad_vec;
   logic [GW-1:0]          grp_sel;

   // Handshake: a transfer happens on a rising edge with valid && ready on the
   // same port; valid holds its payload until taken, ready never looks at valid.
   assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
   assign in_ready = !s1_valid_q || s2_load;
   assign s1_load  = in_valid && in_ready;

   always_comb begin
      pad_vec              = '0;
      pad_vec[WIDTH-1:0]   = in_vec;
      s1_valid_d           = s1_load || (s1_valid_q && !s2_load);
      s1_msb_d             = s1_msb_q;
      s1_any_d             = s1_any_q;
      s1_lidx_d            = s1_lidx_q;
      if (s1_load) begin
         s1_msb_d = in_msb_first;
         for (int g = 0; g < NG; g++) begin
            s1_any_d[g]  = |pad_vec[g*GROUP +: GROUP];
            s1_lidx_d[g] = '0;
            // Scan order is chosen so the last hit is the winner for the mode.
            for (int j = 0; j < GROUP; j++) begin
               if (in_msb_first) begin
                  if (pad_vec[g*GROUP + j]) s1_lidx_d[g] = LW'(j);
               end else begin
                  if (pad_vec[g*GROUP + GROUP - 1 - j]) s1_lidx_d[g] = LW'(GROUP - 1 - j);
               end
            end
         end
      end
   end

   always_comb begin
      grp_sel = '0;
      for (int g = NG - 1; g >= 0; g--) begin
         if (s1_any_q[g] && !s1_msb_q) grp_sel = GW'(g);
      end
      for (int g = 0; g < NG; g++) begin
         if (s1_any_q[g] && s1_msb_q) grp_sel = GW'(g);
      end
      out_valid_d = s2_load || (out_valid_q && !out_ready);
      out_index_d = out_index_q;
      out_zero_d  = out_zero_q;
      if (s2_load) begin
         out_zero_d  = ~|s1_any_q;
         out_index_d = out_zero_d ? '0
                     : IDX_W'(int'(grp_sel) * GROUP + int'(s1_lidx_q[grp_sel]));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_msb_q    <= 1'b0;
         s1_any_q    <= '0;
         s1_lidx_q   <= '0;
         out_valid_q <= 1'b0;
         out_index_q <= '0;
         out_zero_q  <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_msb_q    <= s1_msb_d;
         s1_any_q    <= s1_any_d;
         s1_lidx_q   <= s1_lidx_d;
         out_valid_q <= out_valid_d;
         out_index_q <= out_index_d;
         out_zero_q  <= out_zero_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_index = out_index_q;
   assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Bench for prio_encoder_pipe: directed cases on an 18-bit instance plus a
// randomized soak on 5/18/33-bit instances against a first/last-set-bit model.
module tb_prio_encoder_pipe;

   logic        clk;
   logic        rst_n;
   logic [2:0]  in_valid_v;
   logic [2:0]  in_ready_v;
   logic [2:0]  in_msb_v;
   logic [2:0]  out_valid_v;
   logic [2:0]  out_ready_v;
   logic [2:0]  out_zero_v;
   logic [63:0] in_vec [3];
   logic [2:0]  oi0;
   logic [4:0]  oi1;
   logic [5:0]  oi2;

   int checks = 0;
   int errors = 0;
   int total_acc = 0;
   logic [2:0] acc;
   logic [2:0] hold;
   logic [6:0] held [3];
   logic [6:0] exp_q0[$];
   logic [6:0] exp_q1[$];
   logic [6:0] exp_q2[$];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // ---------------- DUTs ----------------
   prio_encoder_pipe #(.WIDTH(5), .IDX_W(3), .GROUP(4)) u_dut5 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
      .in_vec(in_vec[0][4:0]), .in_msb_first(in_msb_v[0]), .out_valid(out_valid_v[0]),
      .out_ready(out_ready_v[0]), .out_index(oi0), .out_zero(out_zero_v[0]));

   prio_encoder_pipe #(.WIDTH(18), .IDX_W(5), .GROUP(4)) u_dut18 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
      .in_vec(in_vec[1][17:0]), .in_msb_first(in_msb_v[1]), .out_valid(out_valid_v[1]),
      .out_ready(out_ready_v[1]), .out_index(oi1), .out_zero(out_zero_v[1]));

   prio_encoder_pipe #(.WIDTH(33), .IDX_W(6), .GROUP(8)) u_dut33 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
      .in_vec(in_vec[2][32:0]), .in_msb_first(in_msb_v[2]), .out_valid(out_valid_v[2]),
      .out_ready(out_ready_v[2]), .out_index(oi2), .out_zero(out_zero_v[2]));

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic int width_of(input int k);
      case (k)
         0:       return 5;
         1:       return 18;
         default: return 33;
      endcase
   endfunction

   // Result packed as {zero, index[5:0]}.
   function automatic logic [6:0] dut_res(input int k);
      case (k)
         0:       return {out_zero_v[0], 3'b000, oi0};
         1:       return {out_zero_v[1], 1'b0, oi1};
         default: return {out_zero_v[2], oi2};
      endcase
   endfunction

   function automatic logic [6:0] model(input logic [63:0] v, input int w, input logic msb);
      int idx;
      idx = -1;
      for (int i = 0; i < w; i++) begin
         if (v[i] && (msb || idx < 0)) idx = i;
      end
      if (idx < 0) return {1'b1, 6'd0};
      return {1'b0, 6'(idx)};
   endfunction

   function automatic void push_exp(input int k, input logic [6:0] v);
      case (k)
         0:       exp_q0.push_back(v);
         1:       exp_q1.push_back(v);
         default: exp_q2.push_back(v);
      endcase
   endfunction

   function automatic logic [6:0] pop_exp(input int k);
      case (k)
         0:       return exp_q0.pop_front();
         1:       return exp_q1.pop_front();
         default: return exp_q2.pop_front();
      endcase
   endfunction

   function automatic int q_size(input int k);
      case (k)
         0:       return exp_q0.size();
         1:       return exp_q1.size();
         default: return exp_q2.size();
      endcase
   endfunction

   function automatic logic [63:0] gen_vec();
      case ($urandom_range(0, 3))
         0:       return 64'd0;
         1:       return 64'd1 << $urandom_range(0, 63);
         2:       return {$urandom, $urandom};
         default: return {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      endcase
   endfunction

   // ---------------- scoreboard / monitor ----------------
   always @(negedge clk) begin
      #1;
      for (int k = 0; k < 3; k++) begin
         if (!rst_n) begin
            acc[k]  = 1'b0;
            hold[k] = 1'b0;
         end else begin
            acc[k] = in_valid_v[k] && in_ready_v[k];
            if (acc[k]) begin
               push_exp(k, model(in_vec[k], width_of(k), in_msb_v[k]));
               total_acc++;
            end
            if (hold[k]) begin
               check($sformatf("hold_valid_w%0d", width_of(k)), out_valid_v[k], 1);
               check($sformatf("hold_data_w%0d", width_of(k)), dut_res(k), held[k]);
            end
            if (out_valid_v[k] && out_ready_v[k]) begin
               if (q_size(k) == 0)
                  check($sformatf("spurious_out_w%0d", width_of(k)), out_valid_v[k], 0);
               else
                  check($sformatf("result_w%0d", width_of(k)), dut_res(k), pop_exp(k));
            end
            hold[k] = out_valid_v[k] && !out_ready_v[k];
            held[k] = dut_res(k);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_n       = 1'b0;
      in_valid_v  = '0;
      in_msb_v    = '0;
      out_ready_v = '0;
      for (int k = 0; k < 3; k++) in_vec[k] = '0;

      #3;
      for (int k = 0; k < 3; k++) begin
         check("rst_out_valid", out_valid_v[k], 0);
         check("rst_out_data", dut_res(k), 0);
         check("rst_in_ready", in_ready_v[k], 1);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed, 18-bit instance, out_ready high.
      out_ready_v   = 3'b111;
      in_vec[1]     = 64'h28;
      in_msb_v[1]   = 1'b0;
      in_valid_v[1] = 1'b1;
      #1 check("first_accept", in_ready_v[1], 1);
      @(negedge clk);
      in_msb_v[1] = 1'b1;
      #1 check("latency_not_1", out_valid_v[1], 0);
      @(negedge clk);
      check("latency_2_valid", out_valid_v[1], 1);
      check("lsb_0x28", dut_res(1), {1'b0, 6'd3});
      in_vec[1] = 64'h20000; in_msb_v[1] = 1'b0;
      @(negedge clk);
      check("msb_0x28", dut_res(1), {1'b0, 6'd5});
      in_vec[1] = 64'h0;
      @(negedge clk);
      check("top_bit", dut_res(1), {1'b0, 6'd17});
      in_vec[1] = 64'h3FFFF; in_msb_v[1] = 1'b0;
      @(negedge clk);
      check("zero_vec_valid", out_valid_v[1], 1);
      check("zero_vec", dut_res(1), {1'b1, 6'd0});
      in_msb_v[1] = 1'b1;
      @(negedge clk);
      check("all_ones_lsb", dut_res(1), {1'b0, 6'd0});
      in_valid_v[1] = 1'b0;
      @(negedge clk);
      check("all_ones_msb", dut_res(1), {1'b0, 6'd17});
      @(negedge clk);
      check("idle_after_stream", out_valid_v[1], 0);

      // Back-pressure.
      out_ready_v[1] = 1'b0;
      in_vec[1] = 64'h1; in_msb_v[1] = 1'b0; in_valid_v[1] = 1'b1;
      #1 check("bp_ready0", in_ready_v[1], 1);
      @(negedge clk);
      in_vec[1] = 64'h2;
      #1 check("bp_ready1", in_ready_v[1], 1);
      @(negedge clk);
      in_vec[1] = 64'h4;
      #1 check("bp_full", in_ready_v[1], 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check("bp_hold_valid", out_valid_v[1], 1);
         check("bp_hold_idx", dut_res(1), {1'b0, 6'd0});
         check("bp_stall", in_ready_v[1], 0);
      end
      @(negedge clk);
      out_ready_v[1] = 1'b1;
      #1;
      check("drain_idx0", dut_res(1), {1'b0, 6'd0});
      check("drain_ready", in_ready_v[1], 1);
      @(negedge clk);
      in_valid_v[1] = 1'b0;
      check("drain_idx1", dut_res(1), {1'b0, 6'd1});
      @(negedge clk);
      check("drain_idx2", dut_res(1), {1'b0, 6'd2});
      @(negedge clk);
      check("drain_done", out_valid_v[1], 0);

      // Asynchronous reset with both stages full.
      out_ready_v[1] = 1'b0;
      in_vec[1] = 64'h8; in_valid_v[1] = 1'b1;
      @(negedge clk);
      in_vec[1] = 64'h10;
      @(negedge clk);
      in_valid_v[1] = 1'b0;
      #1 check("full_before_rst", out_valid_v[1], 1);
      #1 rst_n = 1'b0;
      #1;
      check("rst_async_valid", out_valid_v[1], 0);
      check("rst_async_data", dut_res(1), 0);
      check("rst_async_ready", in_ready_v[1], 1);
      exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready_v[1] = 1'b1;
      in_vec[1] = 64'h400; in_msb_v[1] = 1'b1; in_valid_v[1] = 1'b1;
      #1 check("post_rst_accept", in_ready_v[1], 1);
      @(negedge clk);
      in_valid_v[1] = 1'b0;
      @(negedge clk);
      check("post_rst_result", dut_res(1), {1'b0, 6'd10});
      for (int i = 0; i < 8; i++) @(negedge clk);
      check("post_rst_no_stale", q_size(1), 0);

      // Random soak across all three widths.
      total_acc = 0;
      for (int cyc = 0; cyc < 40000 && total_acc < 10000; cyc++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (!in_valid_v[k] || acc[k]) begin
               in_valid_v[k] = ($urandom_range(0, 3) != 0);
               in_vec[k]     = gen_vec();
               in_msb_v[k]   = 1'($urandom_range(0, 1));
            end
            out_ready_v[k] = ($urandom_range(0, 3) != 0);
         end
      end
      check("soak_count_reached", (total_acc >= 10000), 1);
      @(negedge clk);
      in_valid_v  = '0;
      out_ready_v = 3'b111;
      for (int i = 0; i < 10; i++) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("final_empty_w%0d", width_of(k)), q_size(k), 0);
         check($sformatf("final_idle_w%0d", width_of(k)), out_valid_v[k], 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/prio_encoder_pipe.md
PRIO_ENCODER_PIPE -- requirements
Module: prio_encoder_pipe

Interface
REQ-001 Parameter WIDTH, default 18: number of request bits; legal range 2..64.
REQ-002 Parameter IDX_W, default 5: index width; SHALL satisfy 2^IDX_W >= WIDTH, checked at elaboration.
REQ-003 Parameter GROUP, default 4: bits per stage-1 sub-encoder; WIDTH need not be a multiple, last group zero-padded.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  in_vec/in_msb_first valid this cycle.
REQ-007 in_ready  output  1  block accepts an input this cycle.
REQ-008 in_vec  input  WIDTH  request vector.
REQ-009 in_msb_first  input  1  0: lowest set bit wins; 1: highest set bit wins; travels with its vector.
REQ-010 out_valid  output  1  out_index/out_zero hold a result.
REQ-011 out_ready  input  1  consumer accepts result this cycle.
REQ-012 out_index  output  IDX_W  position of winning bit.
REQ-013 out_zero  output  1  in_vec was all zeros.

Function
REQ-014 Transfer occurs on a rising edge where valid and ready are both high, on either port.
REQ-015 Two register stages: S1 holds per-group any-flags, per-group local indices and mode; S2 holds final index and zero flag and drives outputs.
REQ-016 Latency: an accepted input appears on out_valid exactly 2 cycles later when out_ready stays high.
REQ-017 S2 loads when S1 holds data and (out_valid == 0 or out_ready == 1).
REQ-018 S1 loads an input when in_valid && in_ready.
REQ-019 S1 keeps its contents when S2 cannot load.
REQ-020 in_ready = !s1_valid || (S2 loads this cycle); combinational, no dependency on in_valid.
REQ-021 Full throughput: one result per cycle sustained while out_ready == 1.
REQ-022 Back-pressure: with out_ready low, at most 2 results buffered (S1 + S2).
REQ-023 Back-pressure: out_index/out_zero/out_valid stable until the output transfer.
REQ-024 LSB-first mode: out_index = smallest i with in_vec[i] == 1.
REQ-025 MSB-first mode: out_index = largest i with in_vec[i] == 1.
REQ-026 Stage-2 group selection uses the same direction as the mode captured with the vector.
REQ-027 All-zero vector: out_zero = 1 and out_index = 0, in both modes.
REQ-028 Otherwise out_zero = 0.
REQ-029 Padding bits beyond WIDTH-1 SHALL never win.
REQ-030 Mode changes between consecutive vectors take effect per vector with no bubble.
REQ-031 No result is dropped, duplicated or reordered.

Reset
REQ-032 While rst_n == 0: out_valid = 0, out_index = 0, out_zero = 0, S1 valid = 0.
REQ-033 While rst_n == 0, in_ready = 1 (combinational from empty S1).
REQ-034 Reset asserted mid-operation discards all in-flight vectors immediately, without waiting for clk.
REQ-035 First input is accepted on the first rising edge after rst_n deasserts.

Verification
REQ-036 WIDTH=18, out_ready=1: vector 0x00028 (LSB mode) -> 2 cycles later out_index=3, out_zero=0.
REQ-037 Same vector, MSB mode -> out_index=5.
REQ-038 Vectors 0x20000 then 0x00000, back-to-back -> consecutive results, no bubble:
- out_index=17, out_zero=0
- out_index=0, out_zero=1
REQ-039 Back-pressure: stream 0x1, 0x2, 0x4 with out_ready=0.
- After 2 accepts in_ready=0.
- Outputs hold index 0.
- Raising out_ready drains indices 0, 1, 2 in order.
REQ-040 Alternating mode, out_ready=1: LSB 0x3FFFF, MSB 0x3FFFF -> indices 0, 17.
REQ-041 Reset mid-stream: assert rst_n=0 with both stages full.
- out_valid=0 before next clk edge.
- After release: no stale result ever appears.
REQ-042 Random soak: 10k vectors, random valid/ready/mode, WIDTH in {5, 18, 33}, results match a reference model in order.
